// File: rtl/pellet_pkg.sv
// rtl/pellet_pkg.sv - shared FSM type, grid constants and window-test helpers for the pellet field
package pellet_pkg;

    typedef enum logic [1:0] {IDLE, CHECK, EAT, REFILL} state_t;

    localparam int CELL_SHIFT = 5;

    // |a-b| <= r, evaluated in 11-bit signed so a < b never wraps
    function automatic logic in_window(input logic [9:0] a, input logic [9:0] b, input logic [9:0] r);
        logic signed [10:0] diff;
        logic [10:0] mag;
        diff = $signed({1'b0, a}) - $signed({1'b0, b});
        mag  = diff[10] ? $unsigned(-diff) : $unsigned(diff);
        return mag <= {1'b0, r};
    endfunction

    function automatic logic is_power_cell(input int col, input int row, input int cols, input int rows);
        return ((col == 1) || (col == cols - 2)) && ((row == 1) || (row == rows - 2));
    endfunction

endpackage

// File: rtl/pellet_pixel_lookup.sv
// rtl/pellet_pixel_lookup.sv - registered pellet_on for the colour mapper; honours POWER_PELLET_EN
module pellet_pixel_lookup
    import pellet_pkg::*;
#(
    parameter int COLS    = 20,
    parameter int ROWS    = 15,
    parameter int CELL_PX = 1 << CELL_SHIFT,
    parameter int DOT_R   = 2
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [9:0]             DrawX,
    input  logic [9:0]             DrawY,
    input  logic [ROWS*COLS-1:0]   bitmap,
    output logic                   pellet_on
);
    localparam int SHIFT = $clog2(CELL_PX);
    localparam int IW    = $clog2(ROWS * COLS);

    logic [9:0]    dcol, drow, xc, yc, radius;
    logic [IW-1:0] idx;
    logic          in_range, hit;

    always_comb begin
        dcol     = DrawX >> SHIFT;
        drow     = DrawY >> SHIFT;
        in_range = (int'(DrawX) < COLS * CELL_PX) && (int'(DrawY) < ROWS * CELL_PX);
        idx      = IW'(int'(drow) * COLS + int'(dcol));
        xc       = 10'(int'(dcol) * CELL_PX + CELL_PX / 2);
        yc       = 10'(int'(drow) * CELL_PX + CELL_PX / 2);
`ifdef POWER_PELLET_EN
        radius   = is_power_cell(int'(dcol), int'(drow), COLS, ROWS) ? 10'(2 * DOT_R) : 10'(DOT_R);
`else
        radius   = 10'(DOT_R);
`endif
        hit      = in_range && bitmap[idx] && in_window(DrawX, xc, radius) && in_window(DrawY, yc, radius);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) pellet_on <= 1'b0;
        else       pellet_on <= hit;
    end

endmodule

// File: rtl/pellet_field.sv
// rtl/pellet_field.sv - pellet maze bitmap, eat/score/refill control; optional POWER_PELLET_EN
module pellet_field
    import pellet_pkg::*;
#(
    parameter int COLS         = 20,
    parameter int ROWS         = 15,
    parameter int CELL_PX      = 1 << CELL_SHIFT,
    parameter int DOT_R        = 2,
    parameter int HOME_COL     = 9,
    parameter int HOME_ROW     = 7,
    parameter int POINTS       = 10,
    parameter int POWER_POINTS = 50,
    parameter int POWER_FRAMES = 360,
    localparam int CNT_W       = $clog2(COLS * ROWS + 1)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             frame_tick,
    input  logic             refill,
    input  logic [9:0]       Xp,
    input  logic [9:0]       Yp,
    input  logic [9:0]       Sizep,
    input  logic [9:0]       DrawX,
    input  logic [9:0]       DrawY,
    output logic             pellet_on,
    output logic             eat_pulse,
    output logic [CNT_W-1:0] remaining,
    output logic [15:0]      score,
    output logic             level_clear,
    output logic             busy,
    output logic             power_active
);
    localparam int SHIFT = $clog2(CELL_PX);
    localparam int NCELL = ROWS * COLS;
    localparam int IW    = $clog2(NCELL);
    localparam int CW    = $clog2(COLS);
    localparam int RW    = $clog2(ROWS);
    localparam logic [NCELL-1:0] FULL_MAP = ~(NCELL'(1) << (HOME_ROW * COLS + HOME_COL));
    localparam logic [CNT_W-1:0] TOTAL    = CNT_W'(NCELL - 1);

    state_t            state, state_nxt;
    logic [NCELL-1:0]  bitmap;
    logic [CW-1:0]     col_q;
    logic [RW-1:0]     row_q, refill_row;
    logic [IW-1:0]     eat_idx;
    logic [9:0]        xc, yc, half;
    logic [15:0]       pts;
    logic [16:0]       score_sum;
    logic              hit;
`ifdef POWER_PELLET_EN
    localparam int TW = $clog2(POWER_FRAMES + 1);
    logic [TW-1:0]     timer;
    logic              power_cell;
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (refill) state_nxt = REFILL;
        else begin
            case (state)
                IDLE:    if (frame_tick) state_nxt = CHECK;
                CHECK:   state_nxt = EAT;
                EAT:     state_nxt = IDLE;
                REFILL:  if (refill_row == RW'(ROWS - 1)) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = (state == REFILL);
        eat_pulse = (state == EAT) && hit && !refill;
`ifdef POWER_PELLET_EN
        power_active = (timer != '0);
`else
        power_active = 1'b0;
`endif
    end

    // Position is sampled live in EAT; only the cell was latched in CHECK
    always_comb begin
        eat_idx   = IW'(int'(row_q) * COLS + int'(col_q));
        xc        = 10'(int'(col_q) * CELL_PX + CELL_PX / 2);
        yc        = 10'(int'(row_q) * CELL_PX + CELL_PX / 2);
        half      = Sizep >> 1;
        hit       = bitmap[eat_idx] && in_window(Xp, xc, half) && in_window(Yp, yc, half);
`ifdef POWER_PELLET_EN
        power_cell = is_power_cell(int'(col_q), int'(row_q), COLS, ROWS);
        pts        = power_cell ? 16'(POWER_POINTS) : 16'(POINTS);
`else
        pts        = 16'(POINTS);
`endif
        score_sum = {1'b0, score} + {1'b0, pts};
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            bitmap      <= FULL_MAP;
            remaining   <= TOTAL;
            score       <= '0;
            level_clear <= 1'b0;
            col_q       <= '0;
            row_q       <= '0;
            refill_row  <= '0;
        end else begin
            level_clear <= (remaining == '0);
            if (refill) begin
                refill_row <= '0;
            end else if (state == REFILL) begin
                bitmap[int'(refill_row) * COLS +: COLS] <= FULL_MAP[int'(refill_row) * COLS +: COLS];
                refill_row <= refill_row + 1'b1;
                if (refill_row == RW'(ROWS - 1)) begin
                    remaining   <= TOTAL;
                    level_clear <= 1'b0;
                end
            end
            if (state == CHECK) begin
                col_q <= (int'(Xp >> SHIFT) > COLS - 1) ? CW'(COLS - 1) : CW'(Xp >> SHIFT);
                row_q <= (int'(Yp >> SHIFT) > ROWS - 1) ? RW'(ROWS - 1) : RW'(Yp >> SHIFT);
            end
            if (eat_pulse) begin
                bitmap[eat_idx] <= 1'b0;
                if (remaining != '0) remaining <= remaining - 1'b1;
                score <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
            end
        end
    end

`ifdef POWER_PELLET_EN
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)                         timer <= '0;
        else if (refill)                   timer <= '0;
        else if (eat_pulse && power_cell)  timer <= TW'(POWER_FRAMES);
        else if (frame_tick && timer != '0) timer <= timer - 1'b1;
    end
`endif

    pellet_pixel_lookup #(
        .COLS    (COLS),
        .ROWS    (ROWS),
        .CELL_PX (CELL_PX),
        .DOT_R   (DOT_R)
    ) u_lookup (
        .Clk       (Clk),
        .Reset     (Reset),
        .DrawX     (DrawX),
        .DrawY     (DrawY),
        .bitmap    (bitmap),
        .pellet_on (pellet_on)
    );

endmodule

// File: tb/tb_pellet_field.sv
// tb/tb_pellet_field.sv - directed self-checking bench for pellet_field
module tb_pellet_field;
    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       refill = 1'b0;
    logic [9:0] Xp = '0, Yp = '0, Sizep = '0, DrawX = '0, DrawY = '0;
    logic       pellet_on, eat_pulse, level_clear, busy, power_active;
    logic [8:0] remaining;
    logic [15:0] score;
    int         total = 0;
    int         bad = 0;
    int         eats, busy_cnt, pulses;
    logic       seen;

    always #5 Clk = ~Clk;

    pellet_field dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_tick   (frame_tick),
        .refill       (refill),
        .Xp           (Xp),
        .Yp           (Yp),
        .Sizep        (Sizep),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .pellet_on    (pellet_on),
        .eat_pulse    (eat_pulse),
        .remaining    (remaining),
        .score        (score),
        .level_clear  (level_clear),
        .busy         (busy),
        .power_active (power_active)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic exp, input string tag);
        DrawX = x;
        DrawY = y;
        @(negedge Clk);
        chk(tag, {31'b0, pellet_on}, {31'b0, exp});
    endtask

    // Called at a negedge with the FSM idle; returns at the negedge after the eat cycle
    task automatic frame(input logic [9:0] x, input logic [9:0] y, input logic [9:0] s, output logic hit);
        Xp = x; Yp = y; Sizep = s; frame_tick = 1'b1;
        @(negedge Clk);
        frame_tick = 1'b0;
        @(negedge Clk);
        hit = eat_pulse;
        @(negedge Clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset state and pixel lookup
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        chk("rst_remaining", remaining, 299);
        chk("rst_score", score, 0);
        chk("rst_eat", eat_pulse, 0);
        chk("rst_pellet_on", pellet_on, 0);
        chk("rst_level_clear", level_clear, 0);
        chk("rst_busy", busy, 0);
        chk("rst_power", power_active, 0);
        pix(10'd304, 10'd240, 1'b0, "pix_home");
        pix(10'd16, 10'd16, 1'b1, "pix_cell00");
        pix(10'd14, 10'd16, 1'b1, "pix_dot_edge");
        pix(10'd13, 10'd16, 1'b0, "pix_dot_outside");
        pix(10'd50, 10'd48, 1'b1, "pix_corner_edge");
`ifdef POWER_PELLET_EN
        pix(10'd51, 10'd48, 1'b1, "pix_power_radius");
`else
        pix(10'd51, 10'd48, 1'b0, "pix_power_radius");
`endif
        pix(10'd640, 10'd16, 1'b0, "pix_x_range");
        pix(10'd16, 10'd480, 1'b0, "pix_y_range");

        // 2: eat latency and no double eat
        Xp = 10'd48; Yp = 10'd16; Sizep = 10'd16; frame_tick = 1'b1;
        @(negedge Clk);
        frame_tick = 1'b0;
        chk("t2_pulse_c1", eat_pulse, 0);
        @(negedge Clk);
        chk("t2_pulse_c2", eat_pulse, 1);
        @(negedge Clk);
        chk("t2_pulse_c3", eat_pulse, 0);
        chk("t2_remaining", remaining, 298);
        chk("t2_score", score, 10);
        frame(10'd48, 10'd16, 10'd16, seen);
        chk("t2_retick", seen, 0);
        chk("t2_remaining2", remaining, 298);
        pix(10'd48, 10'd16, 1'b0, "t2_pix_eaten");

        // 3: box near origin misses the centre
        frame(10'd2, 10'd2, 10'd4, seen);
        chk("t3_no_eat", seen, 0);
        chk("t3_remaining", remaining, 298);

        // 4: clear the board
        eats = 0;
        for (int r = 0; r < 15; r++) begin
            for (int c = 0; c < 20; c++) begin
                frame(10'(c * 32 + 16), 10'(r * 32 + 16), 10'd16, seen);
                if (seen) eats++;
            end
        end
        chk("t4_eats", eats, 298);
        chk("t4_remaining", remaining, 0);
        chk("t4_clear_early", level_clear, 0);
        @(negedge Clk);
        chk("t4_clear", level_clear, 1);
`ifdef POWER_PELLET_EN
        chk("t4_score", score, 3150);
`else
        chk("t4_score", score, 2990);
`endif
        frame(10'd16, 10'd16, 10'd16, seen);
        chk("t4_extra_eat", seen, 0);
        chk("t4_extra_remaining", remaining, 0);
        chk("t4_extra_clear", level_clear, 1);

        // 5: refill coinciding with a tick
        Xp = 10'd16; Yp = 10'd16; Sizep = 10'd16;
        refill = 1'b1; frame_tick = 1'b1;
        @(negedge Clk);
        refill = 1'b0; frame_tick = 1'b0;
        busy_cnt = 0; pulses = 0;
        for (int i = 0; i < 40 && busy; i++) begin
            busy_cnt++;
            if (eat_pulse) pulses++;
            @(negedge Clk);
        end
        chk("t5_busy_cycles", busy_cnt, 15);
        chk("t5_pulses", pulses, 0);
        chk("t5_remaining", remaining, 299);
`ifdef POWER_PELLET_EN
        chk("t5_score", score, 3150);
`else
        chk("t5_score", score, 2990);
`endif
        chk("t5_clear", level_clear, 0);
        pix(10'd16, 10'd16, 1'b1, "t5_pix_restored");
        pix(10'd304, 10'd240, 1'b0, "t5_pix_home");
        refill = 1'b1;
        @(negedge Clk);
        refill = 1'b0;
        repeat (4) @(negedge Clk);
        chk("t5_busy_mid", busy, 1);
        Reset = 1'b1;
        #1;
        chk("t5_reset_busy", busy, 0);
        chk("t5_reset_score", score, 0);
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);

        // 6: corner cell (1,1)
        frame(10'd48, 10'd48, 10'd16, seen);
        chk("t6_eat", seen, 1);
        chk("t6_remaining", remaining, 298);
`ifdef POWER_PELLET_EN
        chk("t6_score", score, 50);
        chk("t6_power_on", power_active, 1);
        for (int i = 0; i < 359; i++) frame(10'd48, 10'd48, 10'd16, seen);
        chk("t6_power_359", power_active, 1);
        frame(10'd48, 10'd48, 10'd16, seen);
        chk("t6_power_off", power_active, 0);
`else
        chk("t6_score", score, 10);
        chk("t6_power_off", power_active, 0);
        for (int i = 0; i < 3; i++) frame(10'd48, 10'd48, 10'd16, seen);
        chk("t6_power_still_off", power_active, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
